// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types.
//   word_t     : 32-bit datapath word
//   regbits_t  : 5-bit architectural register number
//   aluop_t    : ALU operation select
//   fwd_sel_t  : operand source select for EX-stage forwarding
//   exmem_t    : packed contents of the EX/MEM pipeline latch
package cpu_types_pkg;

  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [4:0]        regbits_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    word_t    aluout;
    word_t    store;
    word_t    pcplus4;
    regbits_t writeReg;
    logic     regWEN;
    logic     MemToReg;
    logic     dMemREN;
    logic     dMemWEN;
    logic     halt;
  } exmem_t;

endpackage

// File: rtl/ex_stage_if.sv
// Signal bundle between the ID/EX latch, hazard unit, WB stage and the EX stage.
//   slave  : EX stage view (operands/controls/stall/flush/wb_* in; EX/MEM latch, redirect, overflow out)
//   master : environment view (the reverse)
// Pipeline control semantics: stall holds the EX/MEM latch and suppresses
// redirect; flush loads a bubble and wins over stall; a latched halt freezes
// the latch until reset.
interface ex_stage_if;
  import cpu_types_pkg::*;

  word_t    pcplus4_in, rdat1_in, rdat2_in, immext_in;
  regbits_t rs_in, rt_in, writeReg_in;
  aluop_t   AluOp_in;
  logic [4:0] shamt_in;
  logic     AluSrc_in, MemToReg_in, regWEN_in, dMemREN_in, dMemWEN_in;
  logic     Halt_in, Beq_in, Bne_in, JReg_in;
  logic     stall, flush;
  logic     wb_wen;
  regbits_t wb_reg;
  word_t    wb_data;

  word_t    exmem_aluout, exmem_store, exmem_pcplus4;
  regbits_t exmem_writeReg;
  logic     exmem_regWEN, exmem_MemToReg, exmem_dMemREN, exmem_dMemWEN, exmem_halt;
  logic     redirect;
  word_t    redirect_pc;
  logic     overflow;

  modport slave (
    input  pcplus4_in, rdat1_in, rdat2_in, immext_in, rs_in, rt_in, writeReg_in,
           AluOp_in, shamt_in, AluSrc_in, MemToReg_in, regWEN_in, dMemREN_in,
           dMemWEN_in, Halt_in, Beq_in, Bne_in, JReg_in, stall, flush,
           wb_wen, wb_reg, wb_data,
    output exmem_aluout, exmem_store, exmem_pcplus4, exmem_writeReg,
           exmem_regWEN, exmem_MemToReg, exmem_dMemREN, exmem_dMemWEN,
           exmem_halt, redirect, redirect_pc, overflow
  );

  modport master (
    output pcplus4_in, rdat1_in, rdat2_in, immext_in, rs_in, rt_in, writeReg_in,
           AluOp_in, shamt_in, AluSrc_in, MemToReg_in, regWEN_in, dMemREN_in,
           dMemWEN_in, Halt_in, Beq_in, Bne_in, JReg_in, stall, flush,
           wb_wen, wb_reg, wb_data,
    input  exmem_aluout, exmem_store, exmem_pcplus4, exmem_writeReg,
           exmem_regWEN, exmem_MemToReg, exmem_dMemREN, exmem_dMemWEN,
           exmem_halt, redirect, redirect_pc, overflow
  );

endinterface

// File: rtl/ex_stage_alu.sv
// Combinational 32-bit ALU.
//   op       : operation select
//   a, b     : operands (b already muxed between immediate and rt)
//   rt_val   : shift source (shifts always operate on the rt value)
//   shamt    : shift amount
//   result   : wrapped 32-bit result
//   overflow : signed overflow, ADD/SUB only
module alu
  import cpu_types_pkg::*;
(
  input  aluop_t     op,
  input  word_t      a,
  input  word_t      b,
  input  word_t      rt_val,
  input  logic [4:0] shamt,
  output word_t      result,
  output logic       overflow
);

  word_t sum, diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (op)
      ALU_ADD: begin
        result   = sum;
        // Same-sign operands producing an opposite-sign sum.
        overflow = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      ALU_SUB: begin
        result   = diff;
        // Different-sign operands where the result's sign departs from a.
        overflow = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {31'd0, (a < b)};
      ALU_SLL:  result = rt_val << shamt;
      ALU_SRL:  result = rt_val >> shamt;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch/jr resolution and the
// EX/MEM pipeline latch.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : ex_stage_if.slave (ID/EX operands and controls, hazard
//              stall/flush, WB forwarding source; EX/MEM latch outputs,
//              combinational redirect/redirect_pc/overflow)
// Build option: define FORWARDING_EN to forward from EX/MEM and WB; without
// it the register-file values are used directly and wb_* is ignored.
module ex_stage
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
)
(
  input  logic       CLK,
  input  logic       RST,
  ex_stage_if.slave  bus
);

  logic [WORD_W-1:0] rs_val, rt_val, op_a, op_b, alu_result;
  logic [WORD_W-1:0] branch_target;
  logic              alu_ovf;
  logic              redirect;
  logic [WORD_W-1:0] redirect_pc;
  exmem_t            q, d;

`ifdef FORWARDING_EN
  fwd_sel_t sel_rs, sel_rt;

  // EX/MEM wins over WB; loads are not forwarded from EX/MEM because the
  // data is not available yet; $0 is never forwarded.
  always_comb begin
    sel_rs = FWD_NONE;
    sel_rt = FWD_NONE;
    if (q.regWEN && !q.MemToReg && (q.writeReg == bus.rs_in) && (bus.rs_in != '0))
      sel_rs = FWD_MEM;
    else if (bus.wb_wen && (bus.wb_reg == bus.rs_in) && (bus.rs_in != '0))
      sel_rs = FWD_WB;
    if (q.regWEN && !q.MemToReg && (q.writeReg == bus.rt_in) && (bus.rt_in != '0))
      sel_rt = FWD_MEM;
    else if (bus.wb_wen && (bus.wb_reg == bus.rt_in) && (bus.rt_in != '0))
      sel_rt = FWD_WB;
  end

  always_comb begin
    case (sel_rs)
      FWD_MEM: rs_val = q.aluout;
      FWD_WB:  rs_val = bus.wb_data;
      default: rs_val = bus.rdat1_in;
    endcase
    case (sel_rt)
      FWD_MEM: rt_val = q.aluout;
      FWD_WB:  rt_val = bus.wb_data;
      default: rt_val = bus.rdat2_in;
    endcase
  end
`else
  logic unused_fwd;

  assign rs_val     = bus.rdat1_in;
  assign rt_val     = bus.rdat2_in;
  assign unused_fwd = ^{bus.rs_in, bus.rt_in, bus.wb_wen, bus.wb_reg, bus.wb_data};
`endif

  assign op_a = rs_val;
  assign op_b = bus.AluSrc_in ? bus.immext_in : rt_val;

  alu u_alu (
    .op       (bus.AluOp_in),
    .a        (op_a),
    .b        (op_b),
    .rt_val   (rt_val),
    .shamt    (bus.shamt_in),
    .result   (alu_result),
    .overflow (alu_ovf)
  );

  assign branch_target = bus.pcplus4_in + {bus.immext_in[WORD_W-3:0], 2'b00};

  // JR takes precedence over a simultaneously decoded branch.
  always_comb begin
    redirect    = 1'b0;
    redirect_pc = '0;
    if (!bus.stall) begin
      if (bus.JReg_in) begin
        redirect    = 1'b1;
        redirect_pc = rs_val;
      end else if ((bus.Beq_in && (rs_val == rt_val)) ||
                   (bus.Bne_in && (rs_val != rt_val))) begin
        redirect    = 1'b1;
        redirect_pc = branch_target;
      end
    end
  end

  always_comb begin
    d          = '0;
    d.aluout   = alu_result;
    d.store    = rt_val;
    d.pcplus4  = bus.pcplus4_in;
    d.writeReg = bus.writeReg_in;
    d.regWEN   = bus.regWEN_in && (bus.writeReg_in != '0);
    d.MemToReg = bus.MemToReg_in;
    d.dMemREN  = bus.dMemREN_in;
    d.dMemWEN  = bus.dMemWEN_in;
    d.halt     = bus.Halt_in;
  end

  // A latched halt freezes the latch; otherwise flush beats stall.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q <= '0;
    end else if (!q.halt) begin
      if (bus.flush)
        q <= '0;
      else if (!bus.stall)
        q <= d;
    end
  end

  assign bus.exmem_aluout   = q.aluout;
  assign bus.exmem_store    = q.store;
  assign bus.exmem_pcplus4  = q.pcplus4;
  assign bus.exmem_writeReg = q.writeReg;
  assign bus.exmem_regWEN   = q.regWEN;
  assign bus.exmem_MemToReg = q.MemToReg;
  assign bus.exmem_dMemREN  = q.dMemREN;
  assign bus.exmem_dMemWEN  = q.dMemWEN;
  assign bus.exmem_halt     = q.halt;
  assign bus.redirect       = redirect;
  assign bus.redirect_pc    = redirect_pc;
  assign bus.overflow       = alu_ovf;

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter WORD_W, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port CLK  in  1  pipeline clock, all state on rising edge.
REQ-003 SHALL have port RST  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports pcplus4_in, rdat1_in, rdat2_in, immext_in  in  32 each  operands from ID/EX latch.
REQ-005 SHALL have ports rs_in, rt_in, writeReg_in  in  5 each  source and destination register numbers.
REQ-006 SHALL have ports AluOp_in  in  aluop_t and shamt_in  in  5  ALU operation and shift amount.
REQ-007 SHALL have ports AluSrc_in, MemToReg_in, regWEN_in, dMemREN_in, dMemWEN_in, Halt_in, Beq_in, Bne_in, JReg_in  in  1 each  decoded controls.
REQ-008 SHALL have ports stall, flush  in  1 each  from hazard unit.
REQ-009 SHALL have ports wb_wen  in  1, wb_reg  in  5, wb_data  in  32  WB-stage forwarding source.
REQ-010 SHALL have ports exmem_aluout, exmem_store, exmem_pcplus4  out  32 each  registered EX/MEM data.
REQ-011 SHALL have ports exmem_writeReg  out  5 and exmem_regWEN, exmem_MemToReg, exmem_dMemREN, exmem_dMemWEN, exmem_halt  out  1 each  registered EX/MEM controls.
REQ-012 SHALL have ports redirect  out  1, redirect_pc  out  32, overflow  out  1  combinational branch/jr resolution and ALU flag.

Function
REQ-013 SHALL compute operand A = forwarded rs value; operand B = immext_in when AluSrc_in else forwarded rt value.
REQ-014 SHALL implement ADD, SUB, AND, OR, XOR, NOR, SLT (signed), SLTU, SLL, SRL on 32 bits; shifts use shamt_in on rt value; results wrap mod 2^32.
REQ-015 SHALL assert overflow only for ADD/SUB signed overflow; overflow never suppresses writeback.
REQ-016 SHALL assert redirect when !stall and (Beq_in and A==rt value, or Bne_in and A!=rt value, or JReg_in).
REQ-017 SHALL drive redirect_pc = pcplus4_in + (immext_in<<2) for branches, forwarded rs value for JReg_in, 0 when redirect low.
REQ-018 SHALL on each rising edge: flush -> load bubble (all EX/MEM outputs 0); else stall -> hold all EX/MEM outputs; else capture ALU result, forwarded rt value (as exmem_store) and controls.
REQ-019 SHALL give flush priority over stall when both asserted.
REQ-020 SHALL latch exmem_halt sticky: once 1, all EX/MEM outputs freeze (flush and capture ignored) until RST.
REQ-021 SHALL load exmem_regWEN=0 whenever writeReg_in==0.
REQ-022 SHALL have zero-cycle combinational path to redirect and one-cycle latency to EX/MEM outputs.

Reset
REQ-023 SHALL on RST asynchronously clear every EX/MEM output, including exmem_halt, to 0 regardless of stall/flush.
REQ-024 SHALL resume normal capture on the first rising edge after RST deasserts.

Configuration
REQ-025 SHALL, with FORWARDING_EN defined, select per operand: EX/MEM source (exmem_regWEN, !exmem_MemToReg, exmem_writeReg==reg, reg!=0) over WB source (wb_wen, wb_reg==reg, reg!=0) over register-file value.
REQ-026 SHALL, without FORWARDING_EN, use rdat1_in/rdat2_in directly and ignore wb_* inputs; hazard unit stalls instead.

Structure
REQ-027 SHALL take word_t, regbits_t, aluop_t from cpu_types_pkg and add fwd_sel_t {FWD_NONE, FWD_MEM, FWD_WB} there.
REQ-028 SHALL instantiate one combinational sub-module alu for REQ-014/015; forwarding, branch logic and EX/MEM register live in ex_stage.

Verification
REQ-029 SHALL cover ADD 0x7FFFFFFF+1 -> exmem_aluout 0x80000000 one cycle later, overflow=1; SLTU 1 vs 0xFFFFFFFF -> 1, SLT -> 0.
REQ-030 SHALL cover back-to-back ADD $3 then SUB using $3 with FORWARDING_EN -> FWD_MEM value used; with wb_reg=3 concurrently, MEM wins.
REQ-031 SHALL cover BEQ rs=rt=5, pcplus4=0x40, immext=3 -> redirect=1, redirect_pc=0x4C; same with stall=1 -> redirect=0.
REQ-032 SHALL cover stall and flush together -> bubble loaded; stall alone for 3 cycles -> outputs unchanged.
REQ-033 SHALL cover Halt_in captured -> exmem_halt=1 holds despite later flush; RST mid-stream -> all outputs 0 immediately, before next edge.
REQ-034 SHALL cover write to $0 with regWEN_in=1 -> exmem_regWEN=0 and no forwarding from it.
